qd_multiplier: RTL and testbench
================================

Name: qd_multiplier

Overview:
- Sequential shift-and-add reconstructor, the inverse of the team's non-restoring divider: computes N = Q*D + R from quotient, divisor and remainder.
- Uses the same start/done handshake and one-hot step timing as the divider. Its typical use is the round-trip self-check next to the divider in the Qsys datapath.
- Can also serve as a standalone 8x16 multiply-accumulate unit for software through the same memory-mapped wrapper.

Parameters:
- QW, 8, quotient / multiplier width
- DW, 16, divisor and remainder width; product width PW = QW+DW = 24

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- Q  in  QW  quotient (multiplier), unsigned, sampled on start
- D  in  DW  divisor (multiplicand), unsigned, sampled on start
- R  in  DW  remainder (accumulator seed), unsigned, sampled on start
- start  in  1  single-cycle request; sampled on clk rising edge
- N  out  PW  reconstructed dividend, valid while done=1
- done  out  1  result valid; held until the next start
- busy  out  1  iteration in progress (= ~done & counter nonzero)
- err  out  1  range-check flag (see Optional Feature)

Behaviour:
- Reset (reset_n=0, async): step counter=0, accumulator=0, multiplier shift reg=0, multiplicand reg=0, err=0.
  - Outputs during and after reset: N=0, done=0, busy=0.
  - Block idles with done=0 until the first start; it never self-starts.
- Step counter: 9-bit one-hot cnt.
  - start loads cnt=9'h001.
  - Each edge with ~done shifts cnt left by 1; with done, cnt holds.
  - done = cnt[8]; busy = |cnt[7:0].
- Start edge (edge 0):
  - qreg<=Q, dreg<=zero-extend(D) to PW, acc<=zero-extend(R) to PW.
  - done drops to 0 the following cycle.
- Iteration edges 1..8 (cnt bits 0..7 set):
  - If qreg[0]=1, acc<=acc+dreg, else acc unchanged.
  - Then qreg<=qreg>>1 and dreg<=dreg<<1.
  - All arithmetic is unsigned, PW wide. Overflow is impossible since (2^QW-1)(2^DW-1)+(2^DW-1) < 2^PW, so no saturation logic.
- Latency:
  - done=1 and N final in the cycle after edge 8, i.e. 8 cycles after the start edge.
  - Throughput: one operation per 9 cycles (start may be asserted in the first done cycle).
- N = acc at all times. Intermediate values are visible but are architecturally valid only while done=1.
- start while busy: aborts the current operation and restarts with the new operands. No partial result is flagged.
- start while done: restarts; N and done are unchanged until the start edge.
- start held high for multiple cycles: each edge reloads, so done asserts 8 cycles after the last start edge.
- Q=0: acc stays equal to R; done still takes the full 8 cycles (fixed latency, no early exit).
- reset_n asserted mid-operation: immediate return to reset values, including done=0.

Optional Feature:
- Macro: QD_RANGE_CHECK_EN.
- Defined:
  - On the start edge, err_next = (D==0) | (R >= D), registered with the operands.
  - err is visible only while done=1 (err output = err_reg & done).
  - It flags a remainder that a legal division could not have produced.
  - err clears on the next start or reset.
- Undefined: err tied to 0, no comparator is synthesized, and the port remains present.

Decomposition:
- Package qd_pkg:
  - Localparams QW, DW, PW and STEPS (=QW).
  - Typedef for the one-hot step vector logic [STEPS:0].
  - Shared with the divider wrapper for round-trip benches.
- One natural sub-module, qd_step_counter: one-hot load/shift/hold counter exporting done and busy. It is reusable by the divider refactor.
- The datapath (acc, qreg, dreg) stays in the top.

Test Plan:
- Basic: Q=0x0C, D=0x0011, R=0x0005, start pulse -> done=1 exactly 8 cycles after the start edge; N=0x0000D1, busy=0 once done=1.
- Maximum operands: Q=0xFF, D=0xFFFF, R=0xFFFF -> N=0xFFFF00, no wrap.
- Q=0 and reset behaviour:
  - Q=0x00, D=0x1234, R=0x0007 -> N=0x000007 after the full 8-cycle latency.
  - Before any start, done=0 and N=0.
- Abort/restart:
  - Start Q=0x0C, D=0x0011, R=0x0005; at cycle 4 start Q=0x03, D=0x0100, R=0x0000.
  - Required: done=1 8 cycles after the second start edge, N=0x000300, no done pulse in between.
- Reset mid-operation: reset_n low at cycle 3 of an operation -> N=0 and done=0 asynchronously; no done without a new start after release.
- With QD_RANGE_CHECK_EN defined:
  - R=0x0011, D=0x0011 -> err=1 while done.
  - D=0 -> err=1.
  - R=0x0005, D=0x0011 -> err=0.
  - Without the macro, err=0 for all cases.

Source files
------------

// File: rtl/qd_pkg.sv
// qd_pkg: shared widths and the one-hot step vector type for the
// quotient/divisor reconstructor and the non-restoring divider.
package qd_pkg;

  localparam int QW    = 8;        // quotient / multiplier width
  localparam int DW    = 16;       // divisor and remainder width
  localparam int PW    = QW + DW;  // product / dividend width
  localparam int STEPS = QW;       // one iteration per multiplier bit

  // One-hot step vector: bit k set means iteration k+1 runs on the next
  // edge; the top bit set means the operation is complete.
  typedef logic [STEPS:0] step_t;

endpackage

// File: rtl/qd_step_counter.sv
// qd_step_counter: one-hot load/shift/hold step counter.
// start loads bit 0; each edge shifts left until the top bit is set,
// where the counter holds. done = top bit, busy = any lower bit.
// The counter state is exported on cnt for observation.
module qd_step_counter
  import qd_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  start,
  output logic  done,
  output logic  busy,
  output step_t cnt
);

  step_t cnt_q;
  step_t cnt_d;

  // State register: async clear to the idle (all-zero) pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Next state: start reloads, otherwise shift until the top bit holds.
  always_comb begin
    cnt_d = cnt_q;
    if (start)              cnt_d = step_t'(1);
    else if (!cnt_q[STEPS]) cnt_d = {cnt_q[STEPS-1:0], 1'b0};
  end

  // Outputs decoded directly from the one-hot state.
  always_comb begin
    done = cnt_q[STEPS];
    busy = |cnt_q[STEPS-1:0];
    cnt  = cnt_q;
  end

endmodule

// File: rtl/qd_multiplier.sv
// qd_multiplier: sequential shift-and-add reconstructor, N = Q*D + R.
// One iteration per multiplier bit; done rises 8 cycles after start.
// Optional range check enabled by defining QD_RANGE_CHECK_EN.
//
// Handshake: start is a single-cycle request sampled on the rising edge;
// operands are captured on that edge regardless of current activity (an
// active operation is aborted). done rises when N is final and stays high
// until the next start edge; N is meaningful only while done=1.
module qd_multiplier
  import qd_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic [QW-1:0] Q,
  input  logic [DW-1:0] D,
  input  logic [DW-1:0] R,
  input  logic          start,
  output logic [PW-1:0] N,
  output logic          done,
  output logic          busy,
  output logic          err
);

  logic [QW-1:0] qreg;
  logic [PW-1:0] dreg;
  logic [PW-1:0] acc;
  step_t         cnt;
  logic          iterate;

  qd_step_counter u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .done    (done),
    .busy    (busy),
    .cnt     (cnt)
  );

  // An iteration runs on edges where a low step bit is set; the top-bit
  // term is redundant for a legal one-hot value and keeps it explicit.
  assign iterate = (|cnt[STEPS-1:0]) & ~cnt[STEPS];

  // Datapath: load on start, otherwise conditional add then shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qreg <= '0;
      dreg <= '0;
      acc  <= '0;
    end else if (start) begin
      qreg <= Q;
      dreg <= {{QW{1'b0}}, D};
      acc  <= {{QW{1'b0}}, R};
    end else if (iterate) begin
      if (qreg[0]) acc <= acc + dreg;
      qreg <= qreg >> 1;
      dreg <= dreg << 1;
    end
  end

  assign N = acc;

`ifdef QD_RANGE_CHECK_EN
  logic err_reg;

  // Flag operand sets a legal division could not produce (D=0 or R>=D).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   err_reg <= 1'b0;
    else if (start) err_reg <= (D == '0) | (R >= D);
  end

  assign err = err_reg & done;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qd_multiplier.sv
// tb_qd_multiplier: directed self-checking bench for qd_multiplier.
module tb_qd_multiplier;
  import qd_pkg::*;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic [QW-1:0] Q;
  logic [DW-1:0] D;
  logic [DW-1:0] R;
  logic          start;
  logic [PW-1:0] N;
  logic          done;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  qd_multiplier dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Q       (Q),
    .D       (D),
    .R       (R),
    .start   (start),
    .N       (N),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic exp_err(input logic flag);
`ifdef QD_RANGE_CHECK_EN
    return flag;
`else
    return 1'b0 & flag;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and pulse start across exactly one edge.
  task automatic launch(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r);
    Q = q; D = d; R = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called just after a start edge: wait (bounded) for done and check the
  // latency, the result popped from the expected queue, busy and err.
  task automatic finish_op(input string tag, input logic err_flag);
    int cyc;
    logic [PW-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_err_hidden"}, {31'd0, err}, 32'd0);
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd8);
    check({tag, "_N"}, {8'd0, N}, {8'd0, e});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err(err_flag)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_seen;
    reset_n = 1'b0;
    start = 1'b0; Q = '0; D = '0; R = '0;

    // Reset state and no self-start after release.
    repeat (2) tick();
    check("rst_N", {8'd0, N}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    #3 reset_n = 1'b1;
    repeat (5) tick();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_N", {8'd0, N}, 32'd0);

    // Basic: 12*17+5 = 209.
    exp_q.push_back(24'h0000D1);
    launch(8'h0C, 16'h0011, 16'h0005);
    check("basic_busy_run", {31'd0, busy}, 32'd1);
    finish_op("basic", 1'b0);

    // done and N hold while idle.
    repeat (3) tick();
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_N", {8'd0, N}, 32'h0000D1);

    // Restart from done: before the edge N and done are unchanged.
    Q = 8'hFF; D = 16'hFFFF; R = 16'hFFFF; start = 1'b1;
    #1;
    check("pre_edge_done", {31'd0, done}, 32'd1);
    check("pre_edge_N", {8'd0, N}, 32'h0000D1);
    tick();
    start = 1'b0;
    exp_q.push_back(24'hFFFF00);
    finish_op("max", 1'b1);

    // Back-to-back in the first done cycle: Q=0 keeps N=R.
    exp_q.push_back(24'h000007);
    launch(8'h00, 16'h1234, 16'h0007);
    finish_op("q0", 1'b0);

    // Abort: restart after three iteration edges.
    launch(8'h0C, 16'h0011, 16'h0005);
    done_seen = 0;
    repeat (3) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    exp_q.push_back(24'h000300);
    launch(8'h03, 16'h0100, 16'h0000);
    finish_op("abort", 1'b0);

    // Start held three edges: last operands win, latency from last edge.
    Q = 8'hFF; D = 16'h1111; R = 16'h0000; start = 1'b1;
    tick();
    Q = 8'h7E; D = 16'h2222;
    tick();
    Q = 8'h01; D = 16'h00AA; R = 16'h0001;
    tick();
    start = 1'b0;
    exp_q.push_back(24'h0000AB);
    finish_op("held", 1'b0);

    // Range-check cases: R == D and D == 0.
    exp_q.push_back(24'h000033);
    launch(8'h02, 16'h0011, 16'h0011);
    finish_op("r_eq_d", 1'b1);
    exp_q.push_back(24'h000003);
    launch(8'h05, 16'h0000, 16'h0003);
    finish_op("d_zero", 1'b1);

    // Reset mid-operation: async clear, then no done without a new start.
    launch(8'h0C, 16'h0011, 16'h0005);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_N", {8'd0, N}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    #20 reset_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      tick();
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 32'd0);

    // Operation after recovery.
    exp_q.push_back(24'h0000D1);
    launch(8'h0C, 16'h0011, 16'h0005);
    finish_op("recover", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
